// File: rtl/afe_cfg_pkg.sv
// Shared types and constants for the APB to AFE register-configuration bridge.
package afe_cfg_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } cfg_br_state_e;

   localparam int CFG_DWIDTH     = 32;
   localparam int CFG_AWIDTH_DEF = 11;

endpackage

// File: rtl/afe_cfg_timeout_cnt.sv
// Saturating up-counter for the cfg-ready timeout; o_tc marks the last allowed wait cycle.
// With TIMEOUT_CYCLES = 0 the terminal count never fires.
module afe_cfg_timeout_cnt #(
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic clk_i,
   input  logic rstn_i,
   input  logic i_clr,
   input  logic i_en,
   output logic o_tc
);

   localparam int unsigned   CW      = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] CNT_MAX = '1;
   localparam logic [CW-1:0] CNT_TC  = (TIMEOUT_CYCLES == 0) ? '0 : CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en && (r_cnt != CNT_MAX)) begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

   assign o_tc = (TIMEOUT_CYCLES != 0) && (r_cnt == CNT_TC);

endmodule

// File: rtl/afe_cfg_apb_bridge.sv
// APB3 completer issuing one cfg-bus transfer per APB access, with a ready timeout
// that turns a hung responder into PSLVERR.
//   state | meaning
//   IDLE  | waiting for psel; captures address, write data and direction
//   REQ   | cfg_valid_o high until ready or timeout
//   RESP  | one-cycle PREADY with captured read data / error
module afe_cfg_apb_bridge
   import afe_cfg_pkg::*;
#(
   parameter int                    APB_AWIDTH     = 13,
   parameter int                    CFG_AWIDTH     = CFG_AWIDTH_DEF,
   parameter int unsigned           TIMEOUT_CYCLES = 64,
   parameter logic [CFG_DWIDTH-1:0] ERR_RDATA      = 32'hBADACCE5
) (
   input  logic                  clk_i,
   input  logic                  rstn_i,
   input  logic [APB_AWIDTH-1:0] apb_paddr_i,
   input  logic                  apb_psel_i,
   input  logic                  apb_penable_i,
   input  logic                  apb_pwrite_i,
   input  logic [CFG_DWIDTH-1:0] apb_pwdata_i,
   output logic [CFG_DWIDTH-1:0] apb_prdata_o,
   output logic                  apb_pready_o,
   output logic                  apb_pslverr_o,
   output logic [CFG_AWIDTH-1:0] cfg_addr_o,
   output logic [CFG_DWIDTH-1:0] cfg_data_o,
   output logic                  cfg_valid_o,
   output logic                  cfg_rwn_o,
   input  logic [CFG_DWIDTH-1:0] cfg_data_i,
   input  logic                  cfg_ready_i
);

   cfg_br_state_e         r_state;
   cfg_br_state_e         w_next_state;
   logic [CFG_AWIDTH-1:0] r_addr;
   logic [CFG_DWIDTH-1:0] r_wdata;
   logic [CFG_DWIDTH-1:0] r_rdata;
   logic                  r_rwn;
   logic                  r_err;
   logic                  w_tc;
   logic                  w_cnt_clr;
   logic                  w_cnt_en;
   logic                  w_unused;

   // penable and the byte-lane / decoded upper address bits carry no information here
   assign w_unused = ^{apb_paddr_i, apb_penable_i};

   assign w_cnt_clr = (r_state == IDLE);
   assign w_cnt_en  = (r_state == REQ) && !cfg_ready_i;

   afe_cfg_timeout_cnt #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout_cnt (
      .clk_i (clk_i),
      .rstn_i(rstn_i),
      .i_clr (w_cnt_clr),
      .i_en  (w_cnt_en),
      .o_tc  (w_tc)
   );

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      unique case (r_state)
         IDLE:    if (apb_psel_i) w_next_state = REQ;
         REQ:     if (cfg_ready_i || w_tc) w_next_state = RESP;
         RESP:    w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   always_comb begin
      cfg_valid_o   = (r_state == REQ);
      cfg_addr_o    = r_addr;
      cfg_rwn_o     = r_rwn;
      cfg_data_o    = r_rwn ? '0 : r_wdata;
      apb_pready_o  = (r_state == RESP) && apb_psel_i;
      apb_pslverr_o = (r_state == RESP) && apb_psel_i && r_err;
      apb_prdata_o  = (r_state == RESP) ? r_rdata : '0;
   end

   // Ready is checked before the terminal count so a last-cycle ready is never an error
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_addr  <= '0;
         r_wdata <= '0;
         r_rwn   <= 1'b0;
         r_rdata <= '0;
         r_err   <= 1'b0;
      end else begin
         if ((r_state == IDLE) && apb_psel_i) begin
            r_addr  <= apb_paddr_i[CFG_AWIDTH+1:2];
            r_wdata <= apb_pwdata_i;
            r_rwn   <= ~apb_pwrite_i;
         end
         if (r_state == REQ) begin
            if (cfg_ready_i) begin
               r_rdata <= r_rwn ? cfg_data_i : '0;
               r_err   <= 1'b0;
            end else if (w_tc) begin
               r_rdata <= r_rwn ? ERR_RDATA : '0;
               r_err   <= 1'b1;
            end
         end
      end
   end

endmodule
